// File: rtl/piso_tx_if.sv
// Requester-side word handshake plus serial lane status for the shared PISO transmitter.
interface piso_tx_if #(
  parameter int NUM_REQ = 4,
  parameter int WIDTH   = 8,
  parameter int GW      = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
);
  logic [NUM_REQ-1:0]       req_valid;
  logic [NUM_REQ*WIDTH-1:0] req_data;
  logic [NUM_REQ-1:0]       req_ready;
  logic                     abort;
  logic                     ser_out;
  logic                     ser_valid;
  logic [GW-1:0]            grant_id;
  logic                     done;
  logic                     aborted;
  logic                     busy;

  modport master (
    output req_valid, req_data, abort,
    input  req_ready, ser_out, ser_valid, grant_id, done, aborted, busy
  );

  modport slave (
    input  req_valid, req_data, abort,
    output req_ready, ser_out, ser_valid, grant_id, done, aborted, busy
  );
endinterface

// File: rtl/piso_tx_scheduler.sv
// Round-robin shared serializer: accepts one word per frame, shifts it out a bit
// per clock, then holds the lane idle for GAP_CYCLES before the next grant.
module piso_tx_scheduler #(
  parameter int WIDTH      = 8,
  parameter int NUM_REQ    = 4,
  parameter int SHIFT_DIR  = 0,
  parameter int GAP_CYCLES = 1
) (
  input  logic       clk,
  input  logic       reset,
  piso_tx_if.slave   bus
);
  localparam int GW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {IDLE, SHIFT, GAP} state_t;

  state_t            state, state_nxt;
  logic [GW-1:0]     ptr, winner, gid_q;
  logic              found, accept, last_bit, gap_end;
  logic [WIDTH-1:0]  shadow;
  logic [CW-1:0]     bit_cnt, bit_idx;
  logic [7:0]        gap_cnt;
  logic              ser_q, sv_q, done_q, abt_q;
  logic [NUM_REQ-1:0] ready;
  int                rr_idx;

  // Search starts one past the last accepted index so every requester gets a turn.
  always_comb begin
    winner = '0;
    found  = 1'b0;
    rr_idx = 0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      rr_idx = (int'(ptr) + k) % NUM_REQ;
      if (!found && bus.req_valid[rr_idx]) begin
        found  = 1'b1;
        winner = GW'(rr_idx);
      end
    end
  end

  assign accept   = (state == IDLE) && !bus.abort && found;
  assign last_bit = (bit_cnt == CW'(WIDTH-1));
  assign gap_end  = (gap_cnt == 8'(GAP_CYCLES-1));
  assign bit_idx  = (SHIFT_DIR != 0) ? CW'(WIDTH-1) - bit_cnt : bit_cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:  if (accept) state_nxt = SHIFT;
      SHIFT: begin
        if (bus.abort)     state_nxt = IDLE;
        else if (last_bit) state_nxt = (GAP_CYCLES > 0) ? GAP : IDLE;
      end
      GAP:   if (bus.abort || gap_end) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    ready = '0;
    if (accept) ready[winner] = 1'b1;
  end

  // Serial outputs default low each cycle so done/aborted are single-cycle pulses.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ptr     <= GW'(NUM_REQ-1);
      gid_q   <= '0;
      shadow  <= '0;
      bit_cnt <= '0;
      gap_cnt <= '0;
      ser_q   <= 1'b0;
      sv_q    <= 1'b0;
      done_q  <= 1'b0;
      abt_q   <= 1'b0;
    end else begin
      ser_q  <= 1'b0;
      sv_q   <= 1'b0;
      done_q <= 1'b0;
      abt_q  <= 1'b0;
      case (state)
        IDLE: if (accept) begin
          shadow  <= bus.req_data[int'(winner)*WIDTH +: WIDTH];
          gid_q   <= winner;
          ptr     <= winner;
          bit_cnt <= '0;
        end
        SHIFT: begin
          gap_cnt <= '0;
          if (bus.abort) begin
            abt_q   <= 1'b1;
            bit_cnt <= '0;
          end else begin
            ser_q <= shadow[bit_idx];
            sv_q  <= 1'b1;
            if (last_bit) begin
              done_q  <= 1'b1;
              bit_cnt <= '0;
            end else begin
              bit_cnt <= bit_cnt + 1'b1;
            end
          end
        end
        GAP: begin
          if (bus.abort) begin
            abt_q   <= 1'b1;
            gap_cnt <= '0;
          end else if (gap_end) begin
            gap_cnt <= '0;
          end else begin
            gap_cnt <= gap_cnt + 8'd1;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.req_ready = ready;
  assign bus.ser_out   = ser_q;
  assign bus.ser_valid = sv_q;
  assign bus.grant_id  = gid_q;
  assign bus.done      = done_q;
  assign bus.aborted   = abt_q;
  assign bus.busy      = (state != IDLE);
endmodule
